bpu_pc_gen_2023211063: RTL
==========================

// Module: bpu_pc_gen_2023211063
// PURPOSE
//  Fetch-side consumer of the pre-decode flags: turns inst_jal/inst_jalr/inst_bxx + immediate into a predicted next PC.
//  Owns the architectural fetch PC register and a small return-address stack (RAS) for jalr prediction.
//  Sits between IF (instruction ROM/bus) and the pre-decoder; EX-stage redirects override any prediction.
//  Predicted-taken flag travels down the pipe so EX can detect mispredicts.
// PARAMETERS
//  RAS_DEPTH   4            number of RAS entries (power of 2, >=2)
//  RESET_PC    `CpuResetAddr first fetch address after reset
// PORTS
//  clk                 in   1   core clock
//  rst                 in   1   synchronous, active-high reset
//  inst_i              in   32  instruction fetched at pc_o (rd=[11:7], rs1=[19:15] used for RAS)
//  inst_valid_i        in   1   inst_i/pre-decode flags valid this cycle
//  inst_jal_i          in   1   pre-decode: JAL
//  inst_jalr_i         in   1   pre-decode: JALR
//  inst_bxx_i          in   1   pre-decode: conditional branch
//  jump_and_branch_imm_i in 32  pre-decode: J- or B-immediate (0 otherwise)
//  hold_i              in   1   pipeline stall: freeze PC and RAS
//  ex_redirect_i       in   1   EX resolved a mispredict/jump mismatch
//  ex_redirect_addr_i  in   32  correct target from EX
//  pc_o                out  32  current fetch PC (registered)
//  pred_taken_o        out  1   prediction for instruction at pc_o: redirected away from pc_o+4
//  pred_target_o       out  32  predicted next PC for instruction at pc_o (comb.)
// BEHAVIOUR
//  Reset: pc_o=RESET_PC, RAS pointer=0, RAS count=0, entries=0; pred_taken_o=0 while rst.
//  Next-PC priority (registered into pc_o at clk edge, 1-cycle latency):
//   1 rst -> RESET_PC; 2 ex_redirect_i -> ex_redirect_addr_i (even if hold_i); 3 hold_i -> pc_o unchanged;
//   4 inst_valid_i & predicted taken -> pred_target_o; 5 otherwise pc_o+4.
//  Prediction (comb. from current inputs, only when inst_valid_i):
//   jal              -> taken, target pc_o+imm.
//   bxx              -> taken iff imm[31]=1 (backward, BTFN), target pc_o+imm; forward -> not taken.
//   jalr, pop case & RAS count>0 -> taken, target RAS top with bit0 cleared.
//   jalr, otherwise (non-return or RAS empty) -> not taken, pc_o+4 (EX corrects).
//   none             -> not taken; pred_target_o=pc_o+4.
//  Adds are 32-bit modulo 2^32; wrap past 0xFFFF_FFFC is not flagged.
//  RAS link regs: x1, x5. push = (jal|jalr) & rd is link. pop = jalr & rs1 is link.
//   jalr with both: rd==rs1 -> push only; rd!=rs1 -> pop then push (replace top, count unchanged).
//   Push value pc_o+4. Push when full: overwrite oldest (circular), count saturates at RAS_DEPTH.
//   Pop when empty: no pointer change, no prediction.
//  RAS updates only when inst_valid_i & !hold_i & !ex_redirect_i.
//  ex_redirect_i: RAS not repaired (speculative state kept); no instruction at the old PC updates RAS that cycle.
//  pred_taken_o is combinational for the current pc_o; consumer registers it with the instruction.
//  Reset asserted mid-operation: all state returns to reset values next edge, regardless of hold/redirect.
// STRUCTURE
//  `INST_JAL/`INST_JALR/`INST_TYPE_B, `InstBus, `InstAddrBus, `CpuResetAddr come from defines.vh; add
//  `RAS_LINK_X1 5'd1, `RAS_LINK_X5 5'd5 there.
//  One sub-module: ras_2023211063 (push/pop/replace, top, count; circular buffer with saturating count).
//  Top level holds PC register, prediction mux and priority logic.
// TESTING
//  Reset: hold rst 2 cycles -> pc_o=RESET_PC, pred_taken_o=0; release -> pc_o advances +4 per cycle.
//  jal imm=0x100 at pc 0x10 -> pred_taken_o=1, next pc_o=0x110; bxx imm=0xFFFFFFF0 at 0x20 -> next 0x10;
//   bxx imm=+8 at 0x20 -> not taken, next 0x24.
//  Call/return: jal rd=x1 at 0x40 (imm 0x200), then jalr rs1=x1 rd=x0 at 0x240 -> predicted target 0x44.
//  RAS overflow: 5 nested calls (RAS_DEPTH=4) then 5 returns -> first 4 hit last 4 pushes, 5th not taken (pc+4).
//  hold_i=1 with jal valid -> pc_o and RAS unchanged; ex_redirect_i=1, addr 0x800 with hold_i=1 -> pc_o=0x800.
//  Simultaneous: ex_redirect_i with jal rd=x1 valid -> pc_o=ex addr, RAS count unchanged; rst mid-burst -> reset values.

Source files
------------

// File: rtl/bpu_pc_gen_2023211063_pkg.sv
// Shared types, link-register constants and decode helpers for the fetch PC generator.
package bpu_pc_gen_2023211063_pkg;

   typedef logic [31:0] inst_t;
   typedef logic [31:0] addr_t;

   localparam addr_t      CPU_RESET_ADDR = 32'h0000_0000;
   localparam logic [4:0] RAS_LINK_X1    = 5'd1;
   localparam logic [4:0] RAS_LINK_X5    = 5'd5;

   // Source of the predicted next PC for the instruction at pc_o.
   typedef enum logic [1:0] {
      PredSeq,
      PredJal,
      PredBxx,
      PredRas
   } pred_src_e;

   // x1 and x5 are the conventional link registers used by calls and returns.
   function automatic logic is_link(input logic [4:0] r);
      return (r == RAS_LINK_X1) || (r == RAS_LINK_X5);
   endfunction

endpackage

// File: rtl/bpu_pc_gen_2023211063_if.sv
// Fetch-side bus between the IF/pre-decode stages and the PC generator.
interface bpu_pc_gen_2023211063_if;
   import bpu_pc_gen_2023211063_pkg::*;

   inst_t inst_i;
   logic  inst_valid_i;
   logic  inst_jal_i;
   logic  inst_jalr_i;
   logic  inst_bxx_i;
   addr_t jump_and_branch_imm_i;
   logic  hold_i;
   logic  ex_redirect_i;
   addr_t ex_redirect_addr_i;
   addr_t pc_o;
   logic  pred_taken_o;
   addr_t pred_target_o;

   // Master drives fetch/pre-decode/pipeline-control signals, slave is the PC generator.
   modport master (
      output inst_i, inst_valid_i, inst_jal_i, inst_jalr_i, inst_bxx_i,
             jump_and_branch_imm_i, hold_i, ex_redirect_i, ex_redirect_addr_i,
      input  pc_o, pred_taken_o, pred_target_o
   );

   modport slave (
      input  inst_i, inst_valid_i, inst_jal_i, inst_jalr_i, inst_bxx_i,
             jump_and_branch_imm_i, hold_i, ex_redirect_i, ex_redirect_addr_i,
      output pc_o, pred_taken_o, pred_target_o
   );

endinterface

// File: rtl/bpu_pc_gen_2023211063_ras.sv
// Return-address stack: circular buffer with saturating count.
// push & pop together replaces the top entry when non-empty; pop on empty is ignored.
module ras_2023211063
   import bpu_pc_gen_2023211063_pkg::*;
#(
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  addr_t                      push_val,
   output addr_t                      top,
   output logic [$clog2(RAS_DEPTH):0] count
);

   localparam int unsigned PW = $clog2(RAS_DEPTH);
   localparam logic [PW:0] FULL = (PW + 1)'(RAS_DEPTH);

   addr_t         entries_q [RAS_DEPTH];
   logic [PW-1:0] ptr_q;
   logic [PW-1:0] top_idx;
   logic [PW:0]   count_q;
   logic          not_empty;
   logic          do_replace;
   logic          do_push;
   logic          do_pop;

   // ptr_q points at the next free slot; the top lives one below it (wrapping).
   assign top_idx    = ptr_q - 1'b1;
   assign not_empty  = (count_q != '0);
   assign do_replace = push & pop & not_empty;
   assign do_push    = push & ~do_replace;
   assign do_pop     = pop & ~push & not_empty;

   assign top   = entries_q[top_idx];
   assign count = count_q;

   // Stack state update; a full push overwrites the oldest entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q   <= '0;
         count_q <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            entries_q[i] <= '0;
         end
      end else if (do_replace) begin
         entries_q[top_idx] <= push_val;
      end else if (do_push) begin
         entries_q[ptr_q] <= push_val;
         ptr_q            <= ptr_q + 1'b1;
         if (count_q != FULL) begin
            count_q <= count_q + 1'b1;
         end
      end else if (do_pop) begin
         ptr_q   <= top_idx;
         count_q <= count_q - 1'b1;
      end
   end

endmodule

// File: rtl/bpu_pc_gen_2023211063.sv
// Fetch PC generator: owns the fetch PC, predicts jal/backward-branch/return targets,
// and lets EX redirects override everything except reset.
module bpu_pc_gen_2023211063
   import bpu_pc_gen_2023211063_pkg::*;
#(
   parameter int unsigned RAS_DEPTH = 4,
   parameter addr_t       RESET_PC  = CPU_RESET_ADDR
) (
   input logic                    clk,
   input logic                    rst,
   bpu_pc_gen_2023211063_if.slave bus
);

   addr_t                      pc_q;
   addr_t                      pc_seq;
   addr_t                      pc_rel;
   addr_t                      pred_target;
   addr_t                      ras_top;
   logic [$clog2(RAS_DEPTH):0] ras_count;
   logic [4:0]                 rd;
   logic [4:0]                 rs1;
   logic                       push;
   logic                       pop;
   logic                       ras_en;
   pred_src_e                  pred_src;

   assign rd     = bus.inst_i[11:7];
   assign rs1    = bus.inst_i[19:15];
   assign pc_seq = pc_q + 32'd4;
   assign pc_rel = pc_q + bus.jump_and_branch_imm_i;

   // Link-register hints; jalr with rd == rs1 (both links) is a push only.
   assign push = (bus.inst_jal_i | bus.inst_jalr_i) & is_link(rd);
   assign pop  = bus.inst_jalr_i & is_link(rs1) & ~(is_link(rd) & (rd == rs1));

   // A redirected or stalled instruction must not touch the speculative stack.
   assign ras_en = bus.inst_valid_i & ~bus.hold_i & ~bus.ex_redirect_i & ~rst;

   ras_2023211063 #(
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk      (clk),
      .rst      (rst),
      .push     (ras_en & push),
      .pop      (ras_en & pop),
      .push_val (pc_seq),
      .top      (ras_top),
      .count    (ras_count)
   );

   // Pick the prediction source for the instruction currently at pc_q.
   always_comb begin
      pred_src = PredSeq;
      if (bus.inst_valid_i && !rst) begin
         if (bus.inst_jal_i) begin
            pred_src = PredJal;
         end else if (bus.inst_jalr_i) begin
            if (pop && (ras_count != '0)) begin
               pred_src = PredRas;
            end
         end else if (bus.inst_bxx_i && bus.jump_and_branch_imm_i[31]) begin
            pred_src = PredBxx;
         end
      end
   end

   // Predicted next PC mux.
   always_comb begin
      pred_target = pc_seq;
      case (pred_src)
         PredJal, PredBxx: pred_target = pc_rel;
         PredRas:          pred_target = {ras_top[31:1], 1'b0};
         default:          pred_target = pc_seq;
      endcase
   end

   // Fetch PC: reset, then EX redirect (even under hold), then hold, then prediction.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else if (bus.ex_redirect_i) begin
         pc_q <= bus.ex_redirect_addr_i;
      end else if (!bus.hold_i) begin
         pc_q <= pred_target;
      end
   end

   assign bus.pc_o          = pc_q;
   assign bus.pred_taken_o  = (pred_src != PredSeq);
   assign bus.pred_target_o = pred_target;

endmodule
